mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Next-generation MEM stage of the pipelined RISC-V core: XLEN-generic, byte-lane aware, variable-latency.
//  Takes EX/MEM fields, steers stores to byte lanes, extracts and sign/zero-extends loads, stalls on a
//  req/ack data-memory port, and registers the MEM/WB bundle. Sits between execute and writeback stages.
// PARAMETERS
//  XLEN       32  data/address width; 32 or 64 (64 enables doubleword ls_type)
//  REG_COUNT  32  architectural registers; REG_BITS = $clog2(REG_COUNT)
//  NBYTES     XLEN/8 (localparam) byte lanes; OFS = $clog2(NBYTES) address offset bits
// PORTS
//  clk              in   1         clock
//  rst              in   1         reset, synchronous, active-high
//  in_valid         in   1         EX/MEM bundle valid
//  in_ready         out  1         stage can accept (low = stall upstream)
//  in_rd            in   REG_BITS  destination register
//  in_write_en      in   1         register write enable
//  in_mem_read/in_mem_write in 1   load / store
//  in_ls_type       in   2         00 byte, 01 half, 10 word, 11 double
//  in_load_unsigned in   1         zero-extend load
//  in_wsrc_sel      in   2         writeback source select (passed through)
//  in_alu_out       in   XLEN      effective address / ALU result
//  in_store_data    in   XLEN      rs2 value
//  in_return_pc     in   XLEN      PC+4 (passed through)
//  dmem_req         out  1         memory request, held until dmem_ack
//  dmem_we          out  1         write request
//  dmem_addr        out  XLEN      address, low OFS bits zero
//  dmem_be          out  NBYTES    byte enables
//  dmem_wdata       out  XLEN      lane-steered store data
//  dmem_ack         in   1         request complete; dmem_rdata valid this cycle
//  dmem_rdata       in   XLEN      read word
//  out_valid, out_write_en, out_rd, out_alu_out, out_load_data, out_return_pc, out_wsrc_sel  out  MEM/WB bundle
//  out_exc          out  1         misaligned-access exception (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE; all out_* and dmem_* zero; in_ready=1 (first cycle after rst deasserts).
//  FSM IDLE/WAIT. in_ready = (state==IDLE).
//  IDLE, in_valid, no mem op: register pass-through next cycle, out_valid=1 (latency 1), out_load_data=0.
//  IDLE, in_valid, mem op: capture bundle, go WAIT; dmem_req=1 from next cycle, outputs held stable.
//  mem_read & mem_write both set: treat as store.
//  WAIT & dmem_ack: register result, out_valid=1 next cycle, -> IDLE; ack on first req cycle gives latency 2.
//  out_valid is a single-cycle pulse per accepted bundle; no downstream backpressure.
//  Store: be = size mask << addr[OFS-1:0]; wdata = low size bytes replicated to all lanes.
//  Load: rdata >> (8*addr offset), then extend from size; ls_type 11 with XLEN=32 behaves as word.
//  Sizes wider than lane window never wrap: size mask truncated at NBYTES (aligned-down if misaligned).
//  rst in WAIT: req dropped same edge, captured bundle discarded, no out_valid; memory tolerates abandon.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: addr not size-aligned -> no dmem_req; next cycle out_valid=1,
//   out_exc=1, out_write_en=0, out_alu_out=faulting addr. Undefined: offset bits below size cleared
//   (access aligned down), out_exc tied 0.
// STRUCTURE
//  mem_stage_pkg: ls_type_e enum, state_e {IDLE,WAIT}, size_mask(ls_type) function, XLEN-agnostic helpers.
//  Sub-module mem_lane_align: combinational store steering (be/wdata) and load extract/extend.
// TESTING
//  sw 0xDEADBEEF @0x104, ack after 3 cycles -> be=1111, addr=0x104, out_valid 4 cycles after accept.
//  sb 0x..A5 @0x103 -> be=1000, wdata=0xA5A5A5A5; lb @0x103 rdata 0xA5000000 -> 0xFFFFFFA5; lbu -> 0xA5.
//  lh @0x102 rdata 0x80010000 -> 0xFFFF8001; lhu -> 0x00008001; ack same cycle as req -> latency 2.
//  Non-mem add back-to-back x3 -> out_valid every cycle, in_ready stays 1, dmem_req never set.
//  rst asserted during WAIT -> dmem_req=0 next cycle, no out_valid, later ack ignored.
//  With MEM_MISALIGN_TRAP_EN, lw @0x102 -> out_exc=1, out_write_en=0, no req; without -> access at 0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: load/store size encoding,
// FSM state encoding and XLEN-agnostic size/offset mask helpers.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        LS_BYTE   = 2'b00,
        LS_HALF   = 2'b01,
        LS_WORD   = 2'b10,
        LS_DOUBLE = 2'b11
    } ls_type_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // log2 of the access size in bytes, clamped so it never exceeds the lane window
    function automatic logic [1:0] size_log2(input logic [1:0] ls_type, input int ofs);
        if (int'(ls_type) > ofs) return 2'(ofs);
        return ls_type;
    endfunction

    // Byte-lane mask of an access of 2**lg bytes starting at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] lg);
        case (lg)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Address offset bits that lie below the access size
    function automatic logic [2:0] low_mask(input logic [1:0] lg);
        case (lg)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment: store byte enables and replicated
// write data, plus load extraction and sign/zero extension.
// MEM_MISALIGN_TRAP_EN adds the misaligned-access flag output.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFS = $clog2(NBYTES)
) (
    input  logic [1:0]        ls_type,
    input  logic              load_unsigned,
    input  logic [OFS-1:0]    addr_ofs,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic [NBYTES-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data
);

    logic [1:0]      lg;
    logic [OFS-1:0]  low;
    logic [OFS-1:0]  eff_ofs;
    logic [XLEN-1:0] shifted;
    logic            fill;
    int              nbits;
    int              lane_mask;

    // Size decode, alignment, store steering and load extension
    always_comb begin
        lg        = size_log2(ls_type, OFS);
        low       = OFS'(low_mask(lg));
        lane_mask = int'(low_mask(lg));
        // Offset bits below the size are dropped: a misaligned access is aligned down
        eff_ofs   = addr_ofs & ~low;
        be        = NBYTES'(size_mask(lg)) << eff_ofs;

        // Each lane receives the store byte at (lane index mod size)
        wdata = '0;
        for (int i = 0; i < NBYTES; i++) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (k == (i & lane_mask)) wdata[8*i +: 8] = store_data[8*k +: 8];
            end
        end

        shifted = rdata >> {eff_ofs, 3'b000};
        nbits   = 8 << lg;
        case (lg)
            2'd0:    fill = ~load_unsigned & shifted[7];
            2'd1:    fill = ~load_unsigned & shifted[15];
            2'd2:    fill = ~load_unsigned & shifted[31];
            default: fill = ~load_unsigned & shifted[XLEN-1];
        endcase
        for (int j = 0; j < XLEN; j++) begin
            load_data[j] = (j < nbits) ? shifted[j] : fill;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Any set offset bit below the size means the address is not size-aligned
    always_comb begin
        misaligned = |(addr_ofs & low);
    end
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined core: accepts the EX/MEM bundle, issues one
// data-memory request at a time over a req/ack port, and registers the
// MEM/WB bundle. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of aligning them down.
//
// Handshake: a bundle transfers on a clock edge where in_valid && in_ready.
// in_ready is high only in IDLE. A memory request holds dmem_req and all
// dmem_* fields stable until the edge on which dmem_ack is sampled high.
// out_valid is a one-cycle pulse per accepted bundle; downstream never stalls.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REG_COUNT = 32,
    localparam int REG_BITS = $clog2(REG_COUNT),
    localparam int NBYTES = XLEN / 8,
    localparam int OFS = $clog2(NBYTES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_write_en,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [1:0]          in_ls_type,
    input  logic                in_load_unsigned,
    input  logic [1:0]          in_wsrc_sel,
    input  logic [XLEN-1:0]     in_alu_out,
    input  logic [XLEN-1:0]     in_store_data,
    input  logic [XLEN-1:0]     in_return_pc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [NBYTES-1:0]   dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ack,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                out_valid,
    output logic                out_write_en,
    output logic [REG_BITS-1:0] out_rd,
    output logic [XLEN-1:0]     out_alu_out,
    output logic [XLEN-1:0]     out_load_data,
    output logic [XLEN-1:0]     out_return_pc,
    output logic [1:0]          out_wsrc_sel,
    output logic                out_exc,
    output state_e              dbg_state
);

    state_e              state;
    logic                cap_we;
    logic [REG_BITS-1:0] cap_rd;
    logic                cap_store;
    logic [1:0]          cap_ls;
    logic                cap_uns;
    logic [1:0]          cap_wsrc;
    logic [XLEN-1:0]     cap_alu;
    logic [XLEN-1:0]     cap_pc;

    logic                is_mem;
    logic [1:0]          sel_ls;
    logic                sel_uns;
    logic [OFS-1:0]      sel_ofs;
    logic [NBYTES-1:0]   lane_be;
    logic [XLEN-1:0]     lane_wdata;
    logic [XLEN-1:0]     lane_load;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misaligned;
    logic                exc_q;
`endif

    // The aligner sees the incoming bundle in IDLE and the captured one in WAIT
    always_comb begin
        is_mem   = in_mem_read | in_mem_write;
        in_ready = (state == IDLE);
        sel_ls   = (state == IDLE) ? in_ls_type        : cap_ls;
        sel_uns  = (state == IDLE) ? in_load_unsigned  : cap_uns;
        sel_ofs  = (state == IDLE) ? in_alu_out[OFS-1:0] : cap_alu[OFS-1:0];
    end

    assign dbg_state = state;
`ifdef MEM_MISALIGN_TRAP_EN
    assign out_exc = exc_q;
`else
    assign out_exc = 1'b0;
`endif

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .ls_type       (sel_ls),
        .load_unsigned (sel_uns),
        .addr_ofs      (sel_ofs),
        .store_data    (in_store_data),
        .rdata         (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misaligned    (misaligned),
`endif
        .be            (lane_be),
        .wdata         (lane_wdata),
        .load_data     (lane_load)
    );

    // IDLE/WAIT control with registered memory request and MEM/WB bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cap_we        <= 1'b0;
            cap_rd        <= '0;
            cap_store     <= 1'b0;
            cap_ls        <= 2'b00;
            cap_uns       <= 1'b0;
            cap_wsrc      <= 2'b00;
            cap_alu       <= '0;
            cap_pc        <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_be       <= '0;
            dmem_wdata    <= '0;
            out_valid     <= 1'b0;
            out_write_en  <= 1'b0;
            out_rd        <= '0;
            out_alu_out   <= '0;
            out_load_data <= '0;
            out_return_pc <= '0;
            out_wsrc_sel  <= 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_q         <= 1'b0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem) begin
                            out_valid     <= 1'b1;
                            out_write_en  <= in_write_en;
                            out_rd        <= in_rd;
                            out_alu_out   <= in_alu_out;
                            out_load_data <= '0;
                            out_return_pc <= in_return_pc;
                            out_wsrc_sel  <= in_wsrc_sel;
`ifdef MEM_MISALIGN_TRAP_EN
                            exc_q         <= 1'b0;
                        end else if (misaligned) begin
                            // Faulting access never reaches memory and must not write a register
                            out_valid     <= 1'b1;
                            out_write_en  <= 1'b0;
                            out_rd        <= in_rd;
                            out_alu_out   <= in_alu_out;
                            out_load_data <= '0;
                            out_return_pc <= in_return_pc;
                            out_wsrc_sel  <= in_wsrc_sel;
                            exc_q         <= 1'b1;
`endif
                        end else begin
                            cap_we     <= in_write_en;
                            cap_rd     <= in_rd;
                            cap_store  <= in_mem_write;
                            cap_ls     <= in_ls_type;
                            cap_uns    <= in_load_unsigned;
                            cap_wsrc   <= in_wsrc_sel;
                            cap_alu    <= in_alu_out;
                            cap_pc     <= in_return_pc;
                            // Store wins when both read and write are flagged
                            dmem_req   <= 1'b1;
                            dmem_we    <= in_mem_write;
                            dmem_addr  <= {in_alu_out[XLEN-1:OFS], {OFS{1'b0}}};
                            dmem_be    <= lane_be;
                            dmem_wdata <= in_mem_write ? lane_wdata : '0;
                            state      <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        dmem_we       <= 1'b0;
                        out_valid     <= 1'b1;
                        out_write_en  <= cap_we;
                        out_rd        <= cap_rd;
                        out_alu_out   <= cap_alu;
                        out_load_data <= cap_store ? '0 : lane_load;
                        out_return_pc <= cap_pc;
                        out_wsrc_sel  <= cap_wsrc;
`ifdef MEM_MISALIGN_TRAP_EN
                        exc_q         <= 1'b0;
`endif
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (XLEN=32) with a size/offset
// arithmetic model, expected queues and a per-cycle compare process.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] pc;
        logic [1:0]  wsrc;
        logic        exc;
    } out_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    localparam int OW = $bits(out_t);
    localparam int RW = $bits(req_t);

    logic [OW-1:0] exp_q[$];
    logic [RW-1:0] req_q[$];
    int            lat_q[$];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_write_en;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_ls_type;
    logic        in_load_unsigned;
    logic [1:0]  in_wsrc_sel;
    logic [31:0] in_alu_out;
    logic [31:0] in_store_data;
    logic [31:0] in_return_pc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_write_en;
    logic [4:0]  out_rd;
    logic [31:0] out_alu_out;
    logic [31:0] out_load_data;
    logic [31:0] out_return_pc;
    logic [1:0]  out_wsrc_sel;
    logic        out_exc;
    state_e      dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tag = 1;
    int ack_delay = 1;
    int req_cycles = 0;
    int last_acc = 0;
    int last_obs = 0;
    logic        stray_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_stage #(.XLEN(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_write_en(in_write_en),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_ls_type(in_ls_type), .in_load_unsigned(in_load_unsigned),
        .in_wsrc_sel(in_wsrc_sel), .in_alu_out(in_alu_out),
        .in_store_data(in_store_data), .in_return_pc(in_return_pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_write_en(out_write_en), .out_rd(out_rd),
        .out_alu_out(out_alu_out), .out_load_data(out_load_data),
        .out_return_pc(out_return_pc), .out_wsrc_sel(out_wsrc_sel),
        .out_exc(out_exc), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [1:0] ls);
        return (ls == 2'd0) ? 1 : (ls == 2'd1) ? 2 : 4;
    endfunction

    function automatic int aligned_off(input logic [31:0] alu, input logic [1:0] ls);
        int off;
        off = int'(alu % 4);
        return off - (off % size_of(ls));
    endfunction

    function automatic bit is_misaligned(input logic [31:0] alu, input logic [1:0] ls);
        return (int'(alu % 4) % size_of(ls)) != 0;
    endfunction

    function automatic out_t model_out(input int t, input logic mr, input logic mw,
                                       input logic [1:0] ls, input logic uns,
                                       input logic [31:0] alu, input logic [31:0] rdata);
        out_t   o;
        longint v;
        longint span;
        int     sz;
        bit     trap;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (mr | mw) && is_misaligned(alu, ls);
`endif
        o.we   = 1'b1;
        o.rd   = 5'(t);
        o.alu  = alu;
        o.ld   = 32'h0;
        o.pc   = 32'h1000 + 32'(4 * t);
        o.wsrc = 2'(t);
        o.exc  = 1'b0;
        if (trap) begin
            o.we  = 1'b0;
            o.exc = 1'b1;
        end else if (mr && !mw) begin
            sz   = size_of(ls);
            span = longint'(1) << (8 * sz);
            v = (longint'({32'h0, rdata}) >> (8 * aligned_off(alu, ls))) % span;
            if (!uns && v >= span / 2) v = v - span;
            o.ld = v[31:0];
        end
        return o;
    endfunction

    function automatic req_t model_req(input logic mw, input logic [1:0] ls,
                                       input logic [31:0] alu, input logic [31:0] sd);
        req_t   r;
        int     sz;
        longint rep;
        sz      = size_of(ls);
        rep     = (sz == 1) ? 64'h01010101 : (sz == 2) ? 64'h00010001 : 64'h1;
        r.we    = mw;
        r.addr  = alu & ~32'h3;
        r.be    = 4'(((1 << sz) - 1) << aligned_off(alu, ls));
        r.wdata = mw ? 32'((longint'({32'h0, sd}) % (longint'(1) << (8 * sz))) * rep) : 32'h0;
        return r;
    endfunction

    // ---------------- memory responder ----------------
    always @(posedge clk) begin
        #1;
        if (dmem_req) req_cycles++;
        else req_cycles = 0;
        dmem_ack   = stray_ack | (dmem_req && (req_cycles == ack_delay));
        dmem_rdata = dmem_ack ? mem_rdata : 32'h0;
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; presents one bundle for exactly one edge
    task automatic send(input logic mr, input logic mw, input logic [1:0] ls, input logic uns,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] rdata, input int delay);
        bit mem;
        bit trap;
        mem  = mr | mw;
        trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap = mem && is_misaligned(alu, ls);
`endif
        chk("in_ready_at_send", {63'h0, in_ready}, 64'h1);
        in_valid         = 1'b1;
        in_rd            = 5'(tag);
        in_write_en      = 1'b1;
        in_mem_read      = mr;
        in_mem_write     = mw;
        in_ls_type       = ls;
        in_load_unsigned = uns;
        in_wsrc_sel      = 2'(tag);
        in_alu_out       = alu;
        in_store_data    = sd;
        in_return_pc     = 32'h1000 + 32'(4 * tag);
        mem_rdata        = rdata;
        ack_delay        = delay;
        exp_q.push_back(model_out(tag, mr, mw, ls, uns, alu, rdata));
        lat_q.push_back(cyc + 1 + ((mem && !trap) ? delay : 0));
        if (mem && !trap) req_q.push_back(model_req(mw, ls, alu, sd));
        last_acc = cyc;
        tag++;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        in_mem_write = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin : compare
        req_t re;
        out_t oe;
        if (dmem_req) begin
            chk("in_ready_while_req", {63'h0, in_ready}, 64'h0);
            if (req_q.size() == 0) begin
                chk("unexpected_dmem_req", 64'h1, 64'h0);
            end else begin
                re = req_t'(req_q[0]);
                chk("dmem_we", {63'h0, dmem_we}, {63'h0, re.we});
                chk("dmem_addr", {32'h0, dmem_addr}, {32'h0, re.addr});
                chk("dmem_be", {60'h0, dmem_be}, {60'h0, re.be});
                if (re.we) chk("dmem_wdata", {32'h0, dmem_wdata}, {32'h0, re.wdata});
                if (dmem_ack) void'(req_q.pop_front());
            end
        end
        if (out_valid) begin
            last_obs = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'h1, 64'h0);
            end else begin
                oe = out_t'(exp_q.pop_front());
                chk("out_latency", 64'(cyc), 64'(lat_q.pop_front()));
                chk("out_write_en", {63'h0, out_write_en}, {63'h0, oe.we});
                chk("out_rd", {59'h0, out_rd}, {59'h0, oe.rd});
                chk("out_alu_out", {32'h0, out_alu_out}, {32'h0, oe.alu});
                chk("out_load_data", {32'h0, out_load_data}, {32'h0, oe.ld});
                chk("out_return_pc", {32'h0, out_return_pc}, {32'h0, oe.pc});
                chk("out_wsrc_sel", {62'h0, out_wsrc_sel}, {62'h0, oe.wsrc});
                chk("out_exc", {63'h0, out_exc}, {63'h0, oe.exc});
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- directed sequence ----------------
    initial begin
        out_t m;
        req_t r;
        rst = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_write_en = 1'b0; in_mem_read = 1'b0;
        in_mem_write = 1'b0; in_ls_type = 2'b00; in_load_unsigned = 1'b0;
        in_wsrc_sel = 2'b00; in_alu_out = '0; in_store_data = '0; in_return_pc = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Model pinned to hand-computed values
        m = model_out(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'hA5000000);
        chk("model_lb", {32'h0, m.ld}, 64'hFFFFFFA5);
        m = model_out(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'hA5000000);
        chk("model_lbu", {32'h0, m.ld}, 64'h000000A5);
        m = model_out(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h80010000);
        chk("model_lh", {32'h0, m.ld}, 64'hFFFF8001);
        r = model_req(1'b1, 2'b00, 32'h103, 32'h123456A5);
        chk("model_sb_be", {60'h0, r.be}, 64'h8);
        chk("model_sb_wdata", {32'h0, r.wdata}, 64'hA5A5A5A5);
        r = model_req(1'b1, 2'b01, 32'h106, 32'h1234BEEF);
        chk("model_sh_wdata", {32'h0, r.wdata}, 64'hBEEFBEEF);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_state", {63'h0, dbg_state}, {63'h0, IDLE});
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_dmem_req", {63'h0, dmem_req}, 64'h0);
        chk("rst_dmem_be", {60'h0, dmem_be}, 64'h0);
        chk("rst_dmem_addr", {32'h0, dmem_addr}, 64'h0);
        chk("rst_out_rd", {59'h0, out_rd}, 64'h0);
        chk("rst_out_exc", {63'h0, out_exc}, 64'h0);

        // sw 0xDEADBEEF @0x104, ack on third request cycle
        send(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0, 3);
        wait_done();
        chk("sw_latency", 64'(last_obs - last_acc), 64'd4);

        // sb / lb / lbu at the top lane
        send(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h123456A5, 32'h0, 2);
        wait_done();
        send(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hA5000000, 2);
        wait_done();
        send(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'hA5000000, 1);
        wait_done();

        // lh / lhu with ack on the first request cycle
        send(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80010000, 1);
        wait_done();
        chk("lh_latency", 64'(last_obs - last_acc), 64'd2);
        send(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80010000, 1);
        wait_done();

        // sh on the upper half
        send(1'b0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234BEEF, 32'h0, 2);
        wait_done();

        // Three back-to-back non-memory ops
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'h00000011, 32'h0, 32'h0, 1);
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF0022, 32'h0, 32'h0, 1);
        send(1'b0, 1'b0, 2'b10, 1'b0, 32'h80000033, 32'h0, 32'h0, 1);
        wait_done();
        chk("alu_latency", 64'(last_obs - last_acc), 64'd1);

        // Read and write both set behaves as a store
        send(1'b1, 1'b1, 2'b10, 1'b0, 32'h10C, 32'h0BADF00D, 32'h77777777, 2);
        wait_done();

        // Doubleword size on a 32-bit datapath acts as a word
        send(1'b1, 1'b0, 2'b11, 1'b0, 32'h108, 32'h0, 32'hCAFEBABE, 1);
        wait_done();

        // Misaligned word: trap, or access aligned down to 0x100
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h12345678, 2);
        wait_done();

        // Reset while waiting: request dropped, nothing delivered, stray ack ignored
        send(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h55555555, 100);
        @(posedge clk);
        #1;
        chk("wait_req_before_rst", {63'h0, dmem_req}, 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_wait_dmem_req", {63'h0, dmem_req}, 64'h0);
        chk("rst_wait_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_wait_in_ready", {63'h0, in_ready}, 64'h1);
        exp_q.delete();
        lat_q.delete();
        req_q.delete();
        stray_ack = 1'b1;
        ack_delay = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        stray_ack = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_out_valid", {63'h0, out_valid}, 64'h0);
            chk("post_rst_dmem_req", {63'h0, dmem_req}, 64'h0);
        end

        // Stage recovers after the abandoned access
        send(1'b1, 1'b0, 2'b00, 1'b1, 32'h301, 32'h0, 32'h0000C300, 2);
        wait_done();

        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'h0);
        chk("req_q_drained", 64'(req_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
